if_stage: RTL and testbench

//  Instruction-fetch stage directly upstream of ID. Owns the 16-bit word PC,

---
 rtl/if_stage_if.sv | 21 ++
 rtl/if_stage.sv | 165 ++++++++++++++++
 tb/tb_if_stage.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if
// Instruction-memory request/acknowledge bus between the fetch stage and the
// instruction memory.
//   req   fetch request, held stable together with addr until ack
//   addr  16-bit word address of the requested instruction
//   ack   request completed; data is valid in the same cycle
//   data  32-bit fetched instruction
// Modports:
//   master  fetch stage side (drives req/addr)
//   slave   memory side (drives ack/data)
// ---------------------------------------------------------------------------
interface if_stage_if;
    logic        req;
    logic [15:0] addr;
    logic        ack;
    logic [31:0] data;

    modport master (output req, output addr, input ack, input data);
    modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage in front of ID. Owns the 16-bit word PC, fetches
// 32-bit instructions over the imem req/ack bus and registers {inst, pc} for
// ID. Honours the ID stall by parking an acknowledged instruction in a
// one-entry hold buffer, and takes branch redirects from EX, squashing the
// wrong-path fetch.
//
// Parameters:
//   P_RESET_PC  PC loaded on reset (word address)
//   P_NOP       bubble word presented to ID while valid_o = 0
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   stall_i      ID does not accept an instruction this cycle
//   br_taken_i   single-cycle redirect pulse from EX
//   br_addr_i    redirect target (word address)
//   imem         instruction-memory bus (master side)
//   inst_o       instruction to ID
//   pc_value_o   PC of inst_o
//   valid_o      1 = inst_o is a real instruction, 0 = inst_o is P_NOP
// Optional feature (macro IF_PERF_CNT_EN):
//   perf_fetch_o  saturating count of acks not squashed by a redirect
//   perf_stall_o  saturating count of cycles with stall_i = 1
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [15:0] P_RESET_PC = 16'h0000,
    parameter logic [31:0] P_NOP      = 32'h0800_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               br_taken_i,
    input  logic [15:0]        br_addr_i,
    if_stage_if.master         imem,
    output logic [31:0]        inst_o,
    output logic [15:0]        pc_value_o,
    output logic               valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_o,
    output logic [31:0]        perf_stall_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [31:0] hold_inst, hold_inst_nxt;
    logic [15:0] hold_pc, hold_pc_nxt;
    logic [31:0] inst_nxt;
    logic [15:0] pc_value_nxt;
    logic        valid_nxt;

    // Request and address are decoded straight from state/pc so that they
    // stay stable for as long as the FSM sits in S_REQ at the same pc.
    assign imem.req  = (state == S_REQ);
    assign imem.addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= P_RESET_PC;
            hold_inst  <= P_NOP;
            hold_pc    <= 16'h0000;
            inst_o     <= P_NOP;
            pc_value_o <= 16'h0000;
            valid_o    <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            hold_inst  <= hold_inst_nxt;
            hold_pc    <= hold_pc_nxt;
            inst_o     <= inst_nxt;
            pc_value_o <= pc_value_nxt;
            valid_o    <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        hold_inst_nxt = hold_inst;
        hold_pc_nxt   = hold_pc;
        inst_nxt      = inst_o;
        pc_value_nxt  = pc_value_o;
        valid_nxt     = valid_o;

        if (br_taken_i) begin
            // Redirect beats stall and ack: any same-cycle ack is wrong-path
            // and is dropped, and a pending request is simply withdrawn.
            state_nxt     = S_REQ;
            pc_nxt        = br_addr_i;
            hold_inst_nxt = P_NOP;
            hold_pc_nxt   = 16'h0000;
            inst_nxt      = P_NOP;
            pc_value_nxt  = 16'h0000;
            valid_nxt     = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A late ack left over from before reset lands here and
                    // is ignored.
                    state_nxt = S_REQ;
                end
                S_REQ: begin
                    if (imem.ack && !stall_i) begin
                        inst_nxt     = imem.data;
                        pc_value_nxt = pc;
                        valid_nxt    = 1'b1;
                        pc_nxt       = pc + 16'd1;
                    end else if (imem.ack && stall_i) begin
                        // ID is busy: park the instruction, keep outputs.
                        hold_inst_nxt = imem.data;
                        hold_pc_nxt   = pc;
                        pc_nxt        = pc + 16'd1;
                        state_nxt     = S_HOLD;
                    end else if (!stall_i) begin
                        // Nothing arrived but ID consumed: issue a bubble.
                        inst_nxt  = P_NOP;
                        valid_nxt = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        inst_nxt     = hold_inst;
                        pc_value_nxt = hold_pc;
                        valid_nxt    = 1'b1;
                        state_nxt    = S_REQ;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic fetch_hit;
    assign fetch_hit = (state == S_REQ) && imem.ack && !br_taken_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_o <= 32'h0000_0000;
            perf_stall_o <= 32'h0000_0000;
        end else begin
            if (fetch_hit)
                perf_fetch_o <= sat_inc(perf_fetch_o);
            if (stall_i)
                perf_stall_o <= sat_inc(perf_stall_o);
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [15:0] br_addr = 16'h0000;
    logic [31:0] inst;
    logic [15:0] pcv;
    logic        valid;

    logic        rst2 = 1'b1;
    logic        zero = 1'b0;
    logic [15:0] zero16 = 16'h0000;
    logic [31:0] inst2;
    logic [15:0] pcv2;
    logic        valid2;

    int checks = 0;
    int failures = 0;

    if_stage_if imem_bus ();
    if_stage_if imem_bus2 ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_stall, perf_fetch2, perf_stall2;
`endif

    if_stage u_dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall),
        .br_taken_i (br),
        .br_addr_i  (br_addr),
        .imem       (imem_bus),
        .inst_o     (inst),
        .pc_value_o (pcv),
        .valid_o    (valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_o (perf_fetch),
        .perf_stall_o (perf_stall)
`endif
    );

    if_stage #(.P_RESET_PC(16'hFFFE)) u_wrap (
        .clk        (clk),
        .rst        (rst2),
        .stall_i    (zero),
        .br_taken_i (zero),
        .br_addr_i  (zero16),
        .imem       (imem_bus2),
        .inst_o     (inst2),
        .pc_value_o (pcv2),
        .valid_o    (valid2)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_o (perf_fetch2),
        .perf_stall_o (perf_stall2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        br;
        logic [15:0] br_addr;
        logic        ack;
        logic [31:0] data;
        logic        req;
        logic [15:0] addr;
        logic [31:0] inst;
        logic [15:0] pcv;
        logic        valid;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic logic [31:0] dat(input logic [15:0] a);
        return 32'hC0DE_0000 | {16'h0000, a};
    endfunction

    function automatic vec_t mkv(input logic s, input logic b, input logic [15:0] ba,
                                 input logic k, input logic [31:0] d,
                                 input logic rq, input logic [15:0] ad,
                                 input logic [31:0] in, input logic [15:0] pv,
                                 input logic v);
        vec_t r;
        r.stall = s; r.br = b; r.br_addr = ba; r.ack = k; r.data = d;
        r.req = rq; r.addr = ad; r.inst = in; r.pcv = pv; r.valid = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic rq, input logic [15:0] ad,
                              input logic [31:0] in, input logic [15:0] pv, input logic v);
        check({tag, ".req"},   {31'd0, imem_bus.req}, {31'd0, rq});
        check({tag, ".addr"},  {16'd0, imem_bus.addr}, {16'd0, ad});
        check({tag, ".inst"},  inst, in);
        check({tag, ".pcv"},   {16'd0, pcv}, {16'd0, pv});
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
    endtask

    initial begin
        imem_bus.ack   = 1'b0;
        imem_bus.data  = 32'h0;
        imem_bus2.ack  = 1'b0;
        imem_bus2.data = 32'h0;

        //                 stall br  br_addr   ack  data         req addr      inst          pcv       valid
        vecs[0]  = mkv(0, 0, 16'h0000, 0, 32'h0,        1, 16'h0000, NOP,          16'h0000, 0);
        vecs[1]  = mkv(0, 0, 16'h0000, 0, 32'h0,        1, 16'h0000, NOP,          16'h0000, 0);
        vecs[2]  = mkv(0, 0, 16'h0000, 1, dat(16'h0),   1, 16'h0001, dat(16'h0),   16'h0000, 1);
        vecs[3]  = mkv(0, 0, 16'h0000, 1, dat(16'h1),   1, 16'h0002, dat(16'h1),   16'h0001, 1);
        vecs[4]  = mkv(0, 0, 16'h0000, 0, 32'h0,        1, 16'h0002, NOP,          16'h0001, 0);
        vecs[5]  = mkv(0, 0, 16'h0000, 1, dat(16'h2),   1, 16'h0003, dat(16'h2),   16'h0002, 1);
        vecs[6]  = mkv(0, 0, 16'h0000, 1, dat(16'h3),   1, 16'h0004, dat(16'h3),   16'h0003, 1);
        vecs[7]  = mkv(0, 0, 16'h0000, 1, dat(16'h4),   1, 16'h0005, dat(16'h4),   16'h0004, 1);
        // stall on the ack for pc=5 -> parked, three stalled cycles, release
        vecs[8]  = mkv(1, 0, 16'h0000, 1, dat(16'h5),   0, 16'h0006, dat(16'h4),   16'h0004, 1);
        vecs[9]  = mkv(1, 0, 16'h0000, 0, 32'h0,        0, 16'h0006, dat(16'h4),   16'h0004, 1);
        vecs[10] = mkv(1, 0, 16'h0000, 0, 32'h0,        0, 16'h0006, dat(16'h4),   16'h0004, 1);
        vecs[11] = mkv(0, 0, 16'h0000, 0, 32'h0,        1, 16'h0006, dat(16'h5),   16'h0005, 1);
        vecs[12] = mkv(0, 0, 16'h0000, 1, dat(16'h6),   1, 16'h0007, dat(16'h6),   16'h0006, 1);
        // stall without ack holds everything
        vecs[13] = mkv(1, 0, 16'h0000, 0, 32'h0,        1, 16'h0007, dat(16'h6),   16'h0006, 1);
        vecs[14] = mkv(0, 0, 16'h0000, 1, dat(16'h7),   1, 16'h0008, dat(16'h7),   16'h0007, 1);
        // redirect with simultaneous ack: data dropped
        vecs[15] = mkv(0, 1, 16'h0040, 1, dat(16'h8),   1, 16'h0040, NOP,          16'h0000, 0);
        vecs[16] = mkv(0, 0, 16'h0000, 0, 32'h0,        1, 16'h0040, NOP,          16'h0000, 0);
        vecs[17] = mkv(0, 0, 16'h0000, 1, dat(16'h40),  1, 16'h0041, dat(16'h40),  16'h0040, 1);
        // park 0x41, then redirect while stalled in the hold state
        vecs[18] = mkv(1, 0, 16'h0000, 1, dat(16'h41),  0, 16'h0042, dat(16'h40),  16'h0040, 1);
        vecs[19] = mkv(1, 1, 16'h0040, 0, 32'h0,        1, 16'h0040, NOP,          16'h0000, 0);
        vecs[20] = mkv(0, 0, 16'h0000, 0, 32'h0,        1, 16'h0040, NOP,          16'h0000, 0);
        vecs[21] = mkv(0, 0, 16'h0000, 1, dat(16'h40),  1, 16'h0041, dat(16'h40),  16'h0040, 1);
        vecs[22] = mkv(0, 0, 16'h0000, 1, dat(16'h41),  1, 16'h0042, dat(16'h41),  16'h0041, 1);

        // reset state
        #12;
        check_main("reset", 1'b0, 16'h0000, NOP, 16'h0000, 1'b0);
        check("wrap.reset.addr", {16'd0, imem_bus2.addr}, 32'h0000_FFFE);
        check("wrap.reset.req",  {31'd0, imem_bus2.req}, 32'd0);
`ifdef IF_PERF_CNT_EN
        check("reset.perf_fetch", perf_fetch, 32'd0);
        check("reset.perf_stall", perf_stall, 32'd0);
`endif

        // PC wrap with a reset PC near the top of the address space
        @(negedge clk);
        rst2 = 1'b0;
        @(posedge clk); #1;
        check("wrap.0.req",  {31'd0, imem_bus2.req}, 32'd1);
        check("wrap.0.addr", {16'd0, imem_bus2.addr}, 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            logic [15:0] a;
            a = 16'hFFFE + i[15:0];
            @(negedge clk);
            imem_bus2.ack  = 1'b1;
            imem_bus2.data = dat(a);
            @(posedge clk); #1;
            check("wrap.addr",  {16'd0, imem_bus2.addr}, {16'd0, a + 16'd1});
            check("wrap.pcv",   {16'd0, pcv2}, {16'd0, a});
            check("wrap.inst",  inst2, dat(a));
            check("wrap.valid", {31'd0, valid2}, 32'd1);
        end
        @(negedge clk);
        imem_bus2.ack = 1'b0;

        // main table
        rst = 1'b0;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            stall         = vecs[i].stall;
            br            = vecs[i].br;
            br_addr       = vecs[i].br_addr;
            imem_bus.ack  = vecs[i].ack;
            imem_bus.data = vecs[i].data;
            @(posedge clk); #1;
            check_main($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr,
                       vecs[i].inst, vecs[i].pcv, vecs[i].valid);
        end

        // reset while a request is outstanding
        @(negedge clk);
        stall = 1'b0; br = 1'b0; imem_bus.ack = 1'b0;
        rst = 1'b1;
        #1;
        check_main("midrst", 1'b0, 16'h0000, NOP, 16'h0000, 1'b0);
        imem_bus.ack  = 1'b1;
        imem_bus.data = dat(16'h42);
        @(posedge clk); #1;
        check_main("midrst.held", 1'b0, 16'h0000, NOP, 16'h0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_main("lateack", 1'b1, 16'h0000, NOP, 16'h0000, 1'b0);
`ifdef IF_PERF_CNT_EN
        check("lateack.perf_fetch", perf_fetch, 32'd0);
        check("lateack.perf_stall", perf_stall, 32'd0);
`endif
        @(negedge clk);
        imem_bus.ack  = 1'b1;
        imem_bus.data = dat(16'h0);
        @(posedge clk); #1;
        check_main("restart", 1'b1, 16'h0001, dat(16'h0), 16'h0000, 1'b1);
        @(negedge clk);
        imem_bus.ack = 1'b0;
        stall = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        check_main("restart.stall", 1'b1, 16'h0001, dat(16'h0), 16'h0000, 1'b1);
`ifdef IF_PERF_CNT_EN
        check("restart.perf_fetch", perf_fetch, 32'd1);
        check("restart.perf_stall", perf_stall, 32'd2);
`endif
        @(negedge clk);
        stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
